// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with CSRRW/S/C access, ECALL/MRET and interrupt trap
// sequencing, plus free-running 64-bit cycle and microsecond time counters.
module csr_unit #(
    parameter int          XLEN         = 32,
    parameter int          FMAX_MHz     = 27,
    parameter bit          SUPPORT_USER = 1'b1,
    parameter int unsigned HART_ID      = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    input  logic [2:0]      csr_cmd,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] req_pc,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic [XLEN-1:0] rdata,
    output logic            rvalid,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int PW = FMAX_MHz > 1 ? $clog2(FMAX_MHz) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(FMAX_MHz - 1);

    logic [63:0]     cycle_q, time_q;
    logic [PW-1:0]   presc;
    logic            mode_m, mie_b, mpie;
    logic [1:0]      mpp;
    logic [XLEN-1:0] medeleg, mideleg, mie_r, mtvec, mscratch, mepc, mcause, mtval;
    logic [XLEN-1:0] mip, mstatus, old, wval, tvec_base, trap_pc;
    logic [11:0]     pend;
    logic [3:0]      cause;
    logic            accept, irq, csr_op, ecall, mret, trap, mpp_ok;

    assign mip       = XLEN'({irq_ext, 3'b0, irq_timer, 7'b0});
    assign mstatus   = XLEN'({mpp, 3'b0, mpie, 3'b0, mie_b, 3'b0});
    assign pend      = mie_r[11:0] & mip[11:0] & 12'h880;
    assign irq       = ~flush & mie_b & |pend;
    assign accept    = req_valid & ~flush & (csr_cmd != 3'd0);
    // A pending interrupt pre-empts whatever request shares its cycle
    assign csr_op    = accept & ~irq & mode_m & (csr_cmd inside {3'd1, 3'd2, 3'd3});
    assign ecall     = accept & ~irq & (csr_cmd == 3'd4);
    assign mret      = accept & ~irq & (csr_cmd == 3'd5);
    assign trap      = irq | ecall;
    assign cause     = irq ? (pend[11] ? 4'd11 : 4'd7) : (mode_m ? 4'd11 : 4'd8);
    assign tvec_base = mtvec & ~XLEN'(3);
    assign trap_pc   = (mtvec[0] & irq) ? tvec_base + XLEN'({cause, 2'b00}) : tvec_base;
    assign wval      = csr_cmd == 3'd1 ? csr_wdata :
                       csr_cmd == 3'd2 ? old | csr_wdata : old & ~csr_wdata;
    assign mpp_ok    = SUPPORT_USER && (wval[12:11] == 2'b00 || wval[12:11] == 2'b11);

    always_comb begin
        case (csr_addr)
            12'hC00: old = cycle_q[XLEN-1:0];
            12'hC01: old = time_q[XLEN-1:0];
            12'hC80: old = XLEN == 32 ? XLEN'(cycle_q[63:32]) : '0;
            12'hC81: old = XLEN == 32 ? XLEN'(time_q[63:32]) : '0;
            12'h300: old = mstatus;
            12'h302: old = medeleg;
            12'h303: old = mideleg;
            12'h304: old = mie_r;
            12'h305: old = mtvec & ~XLEN'(2);
            12'h340: old = mscratch;
            12'h341: old = mepc & ~XLEN'(3);
            12'h342: old = mcause;
            12'h343: old = mtval;
            12'h344: old = mip;
            12'hF14: old = XLEN'(HART_ID);
            default: old = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q     <= '0;
            time_q      <= '0;
            presc       <= '0;
            mode_m      <= 1'b1;
            mie_b       <= 1'b0;
            mpie        <= 1'b0;
            mpp         <= 2'b11;
            medeleg     <= '0;
            mideleg     <= '0;
            mie_r       <= '0;
            mtvec       <= '0;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            cycle_q  <= cycle_q + 64'd1;
            presc    <= presc == PRE_MAX ? '0 : presc + PW'(1);
            time_q   <= presc == PRE_MAX ? time_q + 64'd1 : time_q;
            rvalid   <= csr_op;
            redirect <= trap | mret;
            if (csr_op) begin
                rdata <= old;
                case (csr_addr)
                    12'h300: begin
                        mie_b <= wval[3];
                        mpie  <= wval[7];
                        if (mpp_ok) mpp <= wval[12:11];
                    end
                    12'h302: medeleg  <= wval;
                    12'h303: mideleg  <= wval;
                    12'h304: mie_r    <= wval;
                    12'h305: mtvec    <= wval;
                    12'h340: mscratch <= wval;
                    12'h341: mepc     <= wval;
                    12'h342: mcause   <= wval;
                    12'h343: mtval    <= wval;
                    default: ;
                endcase
            end
            if (trap) begin
                mepc        <= req_pc;
                mcause      <= {irq, {(XLEN-5){1'b0}}, cause};
                mpie        <= mie_b;
                mie_b       <= 1'b0;
                mpp         <= mode_m ? 2'b11 : 2'b00;
                mode_m      <= 1'b1;
                redirect_pc <= trap_pc;
            end
            if (mret) begin
                mode_m      <= mpp == 2'b11;
                mie_b       <= mpie;
                mpie        <= 1'b1;
                mpp         <= SUPPORT_USER ? 2'b00 : 2'b11;
                redirect_pc <= mepc & ~XLEN'(3);
            end
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scenarios plus random traffic against a behavioural CSR/trap model.
module tb_csr_unit;
    logic        clk = 0, reset = 0, flush = 0, req_valid = 0;
    logic [2:0]  csr_cmd = 0;
    logic [11:0] csr_addr = 0;
    logic [31:0] csr_wdata = 0, req_pc = 0;
    logic        irq_timer = 0, irq_ext = 0;
    logic [31:0] rdata, redirect_pc;
    logic        rvalid, redirect;
    int          nerr = 0, nchk = 0;

    csr_unit #(.XLEN(32), .FMAX_MHz(27), .SUPPORT_USER(1'b1), .HART_ID(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .csr_cmd(csr_cmd),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .req_pc(req_pc), .irq_timer(irq_timer),
        .irq_ext(irq_ext), .rdata(rdata), .rvalid(rvalid), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // reference model state: privilege level and CSR contents keyed by address
    logic [63:0] m_cycle;
    logic [1:0]  m_priv;
    logic [31:0] m_csr [int];
    logic        m_rvalid, m_redirect;
    logic [31:0] m_rdata, m_rpc;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_rw(logic [11:0] a);
        return a inside {12'h300, 12'h302, 12'h303, 12'h304, 12'h305,
                         12'h340, 12'h341, 12'h342, 12'h343};
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] a);
        logic [63:0] t = m_cycle / 64'd27;
        logic [31:0] mip = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
        case (a)
            12'hC00: return m_cycle[31:0];
            12'hC01: return t[31:0];
            12'hC80: return m_cycle[63:32];
            12'hC81: return t[63:32];
            12'h300: return m_csr[12'h300] & 32'h1888;
            12'h305: return m_csr[12'h305] & 32'hFFFF_FFFD;
            12'h341: return m_csr[12'h341] & 32'hFFFF_FFFC;
            12'h344: return mip;
            default: return m_rw(a) ? m_csr[int'(a)] : 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        int rw_list[9] = '{'h300, 'h302, 'h303, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343};
        m_cycle = 0;
        m_priv  = 2'b11;
        m_csr.delete();
        for (int i = 0; i < 9; i++) m_csr[rw_list[i]] = 32'h0;
        m_csr['h300] = 32'h1800;
        m_rvalid = 0; m_redirect = 0; m_rdata = 0; m_rpc = 0;
    endtask

    task automatic m_trap(logic intr, logic [3:0] cause);
        logic [31:0] ms = m_csr['h300];
        logic [31:0] tv = m_csr['h305];
        m_csr['h341] = req_pc;
        m_csr['h342] = intr ? (32'h8000_0000 | 32'(cause)) : 32'(cause);
        m_csr['h300] = (32'(ms[3]) << 7) | (32'(m_priv) << 11);
        m_priv = 2'b11;
        m_redirect = 1;
        m_rpc = (tv & 32'hFFFF_FFFC) + ((intr && tv[0]) ? 32'(cause) * 4 : 32'h0);
    endtask

    task automatic m_mret();
        logic [31:0] ms = m_csr['h300];
        m_priv = ms[12:11];
        m_csr['h300] = 32'h80 | (32'(ms[7]) << 3);
        m_rpc = m_csr['h341] & 32'hFFFF_FFFC;
        m_redirect = 1;
    endtask

    task automatic m_step();
        logic [31:0] ms = m_csr['h300];
        logic [31:0] pend = m_csr['h304] & {20'b0, irq_ext, 3'b0, irq_timer, 7'b0} & 32'h880;
        logic irq = !flush && ms[3] && pend != 0;
        logic [31:0] old, nv;
        logic [1:0] np;
        m_rvalid = 0;
        m_redirect = 0;
        if (irq) m_trap(1'b1, pend[11] ? 4'd11 : 4'd7);
        else if (req_valid && !flush && csr_cmd != 0) begin
            case (csr_cmd)
                3'd1, 3'd2, 3'd3: if (m_priv == 2'b11) begin
                    old = m_read(csr_addr);
                    nv = csr_cmd == 1 ? csr_wdata : csr_cmd == 2 ? old | csr_wdata : old & ~csr_wdata;
                    m_rvalid = 1;
                    m_rdata = old;
                    if (csr_addr == 12'h300) begin
                        np = nv[12:11];
                        if (!(np == 2'b00 || np == 2'b11)) np = old[12:11];
                        m_csr['h300] = (nv & 32'h88) | (32'(np) << 11);
                    end else if (m_rw(csr_addr)) m_csr[int'(csr_addr)] = nv;
                end
                3'd4: m_trap(1'b0, m_priv == 2'b11 ? 4'd11 : 4'd8);
                3'd5: m_mret();
                default: ;
            endcase
        end
        m_cycle++;
    endtask

    // called on a falling edge: drive, advance model, compare at the next falling edge
    task automatic step(logic v, logic f, logic [2:0] c, logic [11:0] a, logic [31:0] wd,
                        logic [31:0] pc, logic it, logic ie);
        req_valid = v; flush = f; csr_cmd = c; csr_addr = a; csr_wdata = wd; req_pc = pc;
        irq_timer = it; irq_ext = ie;
        m_step();
        @(negedge clk);
        check("rvalid", rvalid, m_rvalid);
        check("redirect", redirect, m_redirect);
        check("rdata", rdata, m_rdata);
        check("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic rd(logic [11:0] a);
        step(1, 0, 3'd2, a, 0, 0, 0, 0);
    endtask

    initial begin
        logic [11:0] addrs[17] = '{'hC00, 'hC01, 'hC80, 'hC81, 'h300, 'h301, 'h302, 'h303, 'h304,
                                   'h305, 'h310, 'h340, 'h341, 'h342, 'h343, 'h344, 'hF14};
        logic [2:0] cmds[16] = '{0, 1, 1, 2, 2, 3, 3, 1, 2, 3, 4, 5, 1, 2, 3, 0};
        logic [2:0] c;
        logic [11:0] a;
        #1 reset = 1;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset_rvalid", rvalid, 0);
        check("reset_redirect", redirect, 0);
        check("reset_rdata", rdata, 0);
        check("reset_rpc", redirect_pc, 0);
        reset = 0;
        repeat (100) step(0, 0, 0, 0, 0, 0, 0, 0);
        rd('hC00); check("t1_cycle", rdata, 100);
        rd('hC01); check("t1_time", rdata, 3);
        rd('hC80); check("t1_cycleh", rdata, 0);
        step(1, 0, 1, 'h305, 'h100, 0, 0, 0);
        step(1, 0, 1, 'h340, 'hF0, 0, 0, 0);
        step(1, 0, 2, 'h340, 'h0F, 0, 0, 0); check("t2_old", rdata, 'hF0); check("t2_rvalid", rvalid, 1);
        rd('h340); check("t2_new", rdata, 'hFF);
        step(1, 0, 2, 'h300, 'h8, 0, 0, 0);
        step(1, 0, 4, 0, 0, 'h40, 0, 0); check("t3_redir", redirect, 1); check("t3_pc", redirect_pc, 'h100);
        rd('h341); check("t3_mepc", rdata, 'h40);
        rd('h342); check("t3_mcause", rdata, 11);
        rd('h300); check("t3_mstatus", rdata, 'h1880);
        step(1, 0, 5, 0, 0, 'h44, 0, 0); check("t3_mret_pc", redirect_pc, 'h40);
        rd('h300); check("t3_mie_back", rdata, 'h88);
        step(1, 0, 1, 'h305, 'h101, 0, 0, 0);
        step(1, 0, 1, 'h304, 'h880, 0, 0, 0);
        step(0, 0, 0, 0, 0, 'h80, 1, 1); check("t4_pc", redirect_pc, 'h12C); check("t4_redir", redirect, 1);
        rd('h342); check("t4_mcause", rdata, 'h8000_000B);
        step(1, 0, 2, 'h300, 'h8, 0, 0, 0);
        step(1, 0, 1, 'h340, 'h55, 'h200, 1, 0);
        check("t5_rvalid", rvalid, 0); check("t5_pc", redirect_pc, 'h11C);
        rd('h340); check("t5_mscratch", rdata, 'hFF);
        rd('h341); check("t5_mepc", rdata, 'h200);
        step(1, 1, 1, 'h340, 'h77, 0, 0, 0); check("t5_flush_rvalid", rvalid, 0);
        rd('h340); check("t5_flush_keep", rdata, 'hFF);
        step(1, 0, 2, 'h300, 'h8, 0, 0, 0);
        step(1, 1, 1, 'h340, 'h77, 'h300, 1, 1); check("t5_flush_irq", redirect, 0);
        rd('h341); check("t5_mepc_keep", rdata, 'h200);
        req_valid = 1; flush = 0; csr_cmd = 4; req_pc = 'h80; irq_timer = 0; irq_ext = 0;
        m_step();
        @(posedge clk); #1;
        check("t6_redir_pre", redirect, 1);
        reset = 1; #1;
        check("t6_redir", redirect, 0);
        check("t6_rvalid", rvalid, 0);
        check("t6_rdata", rdata, 0);
        check("t6_rpc", redirect_pc, 0);
        m_reset();
        req_valid = 0; csr_cmd = 0;
        @(negedge clk);
        reset = 0;
        step(1, 0, 1, 'h300, 'h800, 0, 0, 0); check("t6_old", rdata, 'h1800); check("t6_mode_m", rvalid, 1);
        rd('h300); check("t6_mpp", rdata, 'h1800);
        repeat (3000) begin
            c = cmds[$urandom_range(0, 15)];
            if (m_priv == 2'b00 && c == 3'd5) c = 3'd4;
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 16)];
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, c, a, $urandom, $urandom,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
